// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, FIFO geometry and baud helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PTR_W      = 2;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned DIV_W      = 16;
    localparam int unsigned OSR_W      = 4;
    localparam int unsigned BAUD_W     = DIV_W + OSR_W;
    localparam int unsigned BIT_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    typedef logic [DATA_W-1:0] uart_data_t;

    // Last count of a bit period: 16*(div+1)-1 clk cycles.
    function automatic logic [BAUD_W-1:0] baud_last(input logic [DIV_W-1:0] div);
        return {div, {OSR_W{1'b1}}};
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte write handshake between a producer and the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic       tx_valid;
    uart_data_t tx_data;
    logic       tx_ready;

    modport master (output tx_valid, output tx_data, input  tx_ready);
    modport slave  (input  tx_valid, input  tx_data, output tx_ready);

endinterface

// File: rtl/uart_baud.sv
// Bit-period timer: one-cycle baud_tick at the end of every 16*(cfg_div+1) clk period.
// baud_clear holds the count at zero so the next period starts full length.
module uart_baud
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             baud_clear,
    output logic             baud_tick
);

    logic [BAUD_W-1:0] cnt_q, cnt_d;
    logic [BAUD_W-1:0] last;
    logic              tick_q, tick_d;

    // Tick is registered one cycle early so it is high while cnt_q == last.
    always_comb begin
        last   = baud_last(cfg_div);
        cnt_d  = cnt_q + BAUD_W'(1);
        tick_d = 1'b0;
        if (baud_clear) begin
            cnt_d = '0;
        end else begin
            if (cnt_q >= last) begin
                cnt_d = '0;
            end
            tick_d = (cnt_q == last - BAUD_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign baud_tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 4-entry byte FIFO feeding an 8N1/8N2 serializer, LSB first.
// uart_txd, tx_ready and tx_busy are all flop outputs.
module uart_tx
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_txen,
    input  logic             cfg_nstop,
    uart_tx_if.slave         tx_if,
    output logic             tx_busy,
    output logic             uart_txd
);

    uart_state_e      state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             nstop_q, nstop_d;
    uart_data_t       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_busy_q, tx_busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    uart_data_t       fifo_mem [FIFO_DEPTH];

    logic push;
    logic pop;
    logic baud_clear;
    logic baud_tick;

    uart_baud u_baud (
        .clk        (clk),
        .rst        (rst),
        .cfg_div    (cfg_div),
        .baud_clear (baud_clear),
        .baud_tick  (baud_tick)
    );

    assign baud_clear = (state_q == IDLE);

    // Frame sequencing, FIFO bookkeeping and next values of the output flops.
    always_comb begin
        push      = tx_if.tx_valid & tx_ready_q;
        pop       = 1'b0;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        nstop_d   = nstop_q;
        shift_d   = shift_q;

        unique case (state_q)
            IDLE: begin
                if ((count_q != '0) && cfg_txen) begin
                    pop       = 1'b1;
                    shift_d   = fifo_mem[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        nstop_d   = cfg_nstop;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == BIT_W'(nstop_q)) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        // Line level follows the state being entered so txd lines up with state_q.
        txd_d = 1'b1;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase

        tx_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
        tx_busy_d  = (state_d != IDLE) | (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            nstop_q    <= 1'b0;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            nstop_q    <= nstop_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
            tx_busy_q  <= tx_busy_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Datapath storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (push) begin
            fifo_mem[wr_ptr_q] <= tx_if.tx_data;
        end
    end

    assign tx_if.tx_ready = tx_ready_q;
    assign tx_busy        = tx_busy_q;
    assign uart_txd       = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model, serial line decoder,
// table-driven single-frame vectors, hand-written corner sequences and random traffic.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_div;
    logic        cfg_txen;
    logic        cfg_nstop;
    logic        tx_busy;
    logic        uart_txd;

    uart_tx_if u_if ();

    uart_tx dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_div   (cfg_div),
        .cfg_txen  (cfg_txen),
        .cfg_nstop (cfg_nstop),
        .tx_if     (u_if),
        .tx_busy   (tx_busy),
        .uart_txd  (uart_txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queued bytes plus cycles left in the frame on the wire.
    logic [7:0] m_q[$];
    logic [7:0] sent_log[$];
    logic [7:0] m_byte = 8'h00;
    int         m_left = 0;
    int         m_len  = 1;
    int         m_p    = 16;

    initial begin : ref_model
        forever begin
            @(posedge clk or negedge rst);
            if (rst !== 1'b1) begin
                m_q.delete();
                m_left = 0;
            end else begin
                logic do_pop;
                logic do_push;
                do_pop  = (m_left == 0) && (m_q.size() != 0) && (cfg_txen === 1'b1);
                do_push = (u_if.tx_valid === 1'b1) && (m_q.size() < 4);
                if (do_pop) begin
                    m_byte = m_q.pop_front();
                    sent_log.push_back(m_byte);
                    m_p    = 16 * (int'(cfg_div) + 1);
                    m_len  = (10 + int'(cfg_nstop)) * m_p;
                    m_left = m_len;
                end else if (m_left > 0) begin
                    m_left = m_left - 1;
                end
                if (do_push) m_q.push_back(u_if.tx_data);
            end
        end
    end

    // Serial line decoder, as a receiver would see it; frames overlapped by reset are dropped.
    logic [7:0] rx_q[$];

    initial begin : line_decoder
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && uart_txd === 1'b0) begin
                int         p;
                logic       bad;
                logic [7:0] b;
                p   = 16 * (int'(cfg_div) + 1);
                bad = 1'b0;
                b   = 8'h00;
                for (int c = 0; c < p / 2; c++) begin
                    @(negedge clk);
                    bad = bad | (rst !== 1'b1);
                end
                bad = bad | (uart_txd !== 1'b0);
                for (int i = 0; i < 8; i++) begin
                    for (int c = 0; c < p; c++) begin
                        @(negedge clk);
                        bad = bad | (rst !== 1'b1);
                    end
                    b[i] = uart_txd;
                end
                for (int c = 0; c < p; c++) begin
                    @(negedge clk);
                    bad = bad | (rst !== 1'b1);
                end
                bad = bad | (uart_txd !== 1'b1);
                if (!bad) rx_q.push_back(b);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Advance one cycle and compare all outputs with the model.
    task automatic tick();
        logic e_txd;
        logic e_rdy;
        logic e_busy;
        int   k;
        @(negedge clk);
        e_txd = 1'b1;
        if (m_left > 0) begin
            k = (m_len - m_left) / m_p;
            if (k == 0) e_txd = 1'b0;
            else if (k <= 8) e_txd = m_byte[k-1];
        end
        e_rdy  = (m_q.size() < 4);
        e_busy = (m_left > 0) || (m_q.size() != 0);
        n_checks++;
        if ({uart_txd, u_if.tx_ready, tx_busy} === {e_txd, e_rdy, e_busy}) n_pass++;
        else $display("FAIL cycle t=%0t txd=%b exp %b ready=%b exp %b busy=%b exp %b",
                      $time, uart_txd, e_txd, u_if.tx_ready, e_rdy, tx_busy, e_busy);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (tx_busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain", 32'(tx_busy), 32'd0);
        repeat (4) tick();
    endtask

    task automatic write_byte(input logic [7:0] d);
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = d;
        tick();
        u_if.tx_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] div;
        logic        nstop;
        logic [7:0]  data;
        logic [11:0] exp_frame;
        int          exp_busy;
    } vec_t;

    vec_t vecs[4];

    initial begin : main
        int         rx_base;
        int         sl_base;
        logic [7:0] bb[5];
        logic [7:0] tq[4];

        vecs[0] = '{16'd0, 1'b0, 8'hA5, {2'b00, 1'b1,  8'hA5, 1'b0}, 160};
        vecs[1] = '{16'd0, 1'b1, 8'h00, {1'b0,  2'b11, 8'h00, 1'b0}, 176};
        vecs[2] = '{16'd1, 1'b0, 8'h3C, {2'b00, 1'b1,  8'h3C, 1'b0}, 320};
        vecs[3] = '{16'd2, 1'b1, 8'hFF, {1'b0,  2'b11, 8'hFF, 1'b0}, 528};

        rst           = 1'b1;
        cfg_div       = 16'd0;
        cfg_txen      = 1'b1;
        cfg_nstop     = 1'b0;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        #3 rst = 1'b0;
        repeat (3) tick();
        chk("rst_txd",   32'(uart_txd),      32'd1);
        chk("rst_ready", 32'(u_if.tx_ready), 32'd1);
        chk("rst_busy",  32'(tx_busy),       32'd0);
        rst = 1'b1;
        repeat (3) tick();

        // Single frames: line pattern sampled mid-bit and start-to-idle length.
        for (int i = 0; i < 4; i++) begin
            logic        found;
            logic [11:0] got;
            int          cyc;
            int          p;
            cfg_div   = vecs[i].div;
            cfg_nstop = vecs[i].nstop;
            write_byte(vecs[i].data);
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                tick();
                if (uart_txd === 1'b0) found = 1'b1;
            end
            chk("start_seen", 32'(found), 32'd1);
            got = 12'h000;
            cyc = 0;
            p   = 16 * (int'(vecs[i].div) + 1);
            while (found && tx_busy === 1'b1 && cyc < 2000) begin
                if ((cyc % p) == p / 2 && (cyc / p) < 12) got[cyc / p] = uart_txd;
                tick();
                cyc++;
            end
            chk("frame_bits", 32'(got), 32'(vecs[i].exp_frame));
            chk("busy_len",   32'(cyc), 32'(vecs[i].exp_busy));
            repeat (4) tick();
        end

        // Five writes in consecutive cycles, then one more while full.
        cfg_div   = 16'd0;
        cfg_nstop = 1'b0;
        rx_base   = rx_q.size();
        for (int j = 0; j < 5; j++) bb[j] = 8'($urandom);
        for (int j = 0; j < 5; j++) begin
            u_if.tx_valid = 1'b1;
            u_if.tx_data  = bb[j];
            tick();
        end
        chk("full_ready", 32'(u_if.tx_ready), 32'd0);
        u_if.tx_data = ~bb[4];
        tick();
        u_if.tx_valid = 1'b0;
        wait_idle(3000);
        chk("burst_cnt", 32'(rx_q.size() - rx_base), 32'd5);
        for (int j = 0; j < 5; j++)
            if (rx_base + j < rx_q.size()) chk("burst_byte", 32'(rx_q[rx_base + j]), 32'(bb[j]));

        // Transmit enable gating.
        for (int j = 0; j < 4; j++) tq[j] = 8'($urandom);
        rx_base  = rx_q.size();
        cfg_txen = 1'b0;
        write_byte(tq[0]);
        write_byte(tq[1]);
        repeat (60) tick();
        chk("txen0_rx",    32'(rx_q.size() - rx_base), 32'd0);
        chk("txen0_busy",  32'(tx_busy),               32'd1);
        chk("txen0_ready", 32'(u_if.tx_ready),         32'd1);
        cfg_txen = 1'b1;
        wait_idle(1000);
        chk("txen1_rx", 32'(rx_q.size() - rx_base), 32'd2);
        write_byte(tq[2]);
        write_byte(tq[3]);
        repeat (30) tick();
        cfg_txen = 1'b0;
        repeat (400) tick();
        chk("txen_mid_rx",   32'(rx_q.size() - rx_base), 32'd3);
        chk("txen_mid_busy", 32'(tx_busy),               32'd1);
        cfg_txen = 1'b1;
        wait_idle(1000);
        chk("txen_all_rx", 32'(rx_q.size() - rx_base), 32'd4);
        for (int j = 0; j < 4; j++)
            if (rx_base + j < rx_q.size()) chk("txen_byte", 32'(rx_q[rx_base + j]), 32'(tq[j]));

        // Reset during the data phase of 0x3C with a second byte queued.
        rx_base = rx_q.size();
        write_byte(8'h3C);
        write_byte(8'h81);
        begin
            logic found;
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                tick();
                if (uart_txd === 1'b0) found = 1'b1;
            end
            chk("abort_start", 32'(found), 32'd1);
        end
        repeat (20) tick();
        chk("abort_pre_txd", 32'(uart_txd), 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("abort_txd",   32'(uart_txd),      32'd1);
        chk("abort_busy",  32'(tx_busy),       32'd0);
        chk("abort_ready", 32'(u_if.tx_ready), 32'd1);
        repeat (3) tick();
        rst = 1'b1;
        repeat (300) tick();
        chk("abort_idle", 32'(tx_busy),                 32'd0);
        chk("abort_rx",   32'(rx_q.size() - rx_base),   32'd0);

        // Random traffic against the model, two line configurations.
        for (int ph = 0; ph < 2; ph++) begin
            cfg_div   = 16'(ph);
            cfg_nstop = 1'(ph);
            cfg_txen  = 1'b1;
            rx_base   = rx_q.size();
            sl_base   = sent_log.size();
            for (int c = 0; c < 2500; c++) begin
                u_if.tx_valid = ($urandom_range(0, 3) == 0);
                u_if.tx_data  = 8'($urandom);
                if ($urandom_range(0, 299) == 0) cfg_txen = ~cfg_txen;
                tick();
            end
            u_if.tx_valid = 1'b0;
            cfg_txen      = 1'b1;
            wait_idle(6000);
            chk("rand_cnt", 32'(rx_q.size() - rx_base), 32'(sent_log.size() - sl_base));
            for (int j = 0; rx_base + j < rx_q.size() && sl_base + j < sent_log.size(); j++)
                chk("rand_byte", 32'(rx_q[rx_base + j]), 32'(sent_log[sl_base + j]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
